// File: rtl/jtkcpu_seqdiv.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, signed or unsigned, with overflow and divide-by-zero flags.
// Optional build macro JTKCPU_SEQDIV_RADIX4_EN retires two quotient bits per cycle.
module jtkcpu_seqdiv #(
    parameter int unsigned W = 8
) (
    input  logic           rst,
    input  logic           clk,
    input  logic           cen,
    input  logic           start,
    input  logic           sign,
    input  logic           len,
    input  logic [2*W-1:0] op0,
    input  logic [W-1:0]   op1,
    output logic [W-1:0]   quot,
    output logic [W-1:0]   rem,
    output logic           busy,
    output logic           done,
    output logic           v,
    output logic           dz
);

    localparam int unsigned DW = 2 * W;
`ifdef JTKCPU_SEQDIV_RADIX4_EN
    localparam int unsigned STEPS = W / 2;
`else
    localparam int unsigned STEPS = W;
`endif
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    localparam logic [W-1:0]  HALF = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    pr, lo, dvs, lo_raw;
    logic            qneg, rneg, dz_r;

    logic [DW-1:0]   dvd_c, dvd_mag_c;
    logic [W-1:0]    dvs_mag_c;
    logic            dvd_neg_c, dvs_neg_c, dz_c, ovf_c;
    logic [W:0]      s1;
    logic [W-1:0]    pr_step, lo_step;
    logic [W-1:0]    q_fix, r_fix;
    logic            sovf;
    logic            commit, busy_nxt, v_nxt, dz_nxt;
    logic [W-1:0]    q_nxt, r_nxt;

    // One restoring step: returns {new partial remainder, quotient bit}
    function automatic logic [W:0] div_step(input logic [W-1:0] p, input logic b,
                                            input logic [W-1:0] d);
        logic [W:0] t, diff;
        t    = {p, b};
        diff = t - {1'b0, d};
        if (t >= {1'b0, d}) div_step = {diff[W-1:0], 1'b1};
        else                div_step = {t[W-1:0], 1'b0};
    endfunction

    // Operand preparation for the accepting edge
    always_comb begin
        dvd_c     = len ? op0 : (sign ? {{W{op0[W-1]}}, op0[W-1:0]} : {{W{1'b0}}, op0[W-1:0]});
        dvd_neg_c = sign & dvd_c[DW-1];
        dvs_neg_c = sign & op1[W-1];
        dvd_mag_c = dvd_neg_c ? (~dvd_c + DW'(1)) : dvd_c;
        dvs_mag_c = dvs_neg_c ? (~op1 + W'(1)) : op1;
        dz_c      = (op1 == '0);
        ovf_c     = (dvd_mag_c[DW-1:W] >= dvs_mag_c);
    end

`ifdef JTKCPU_SEQDIV_RADIX4_EN
    logic [W:0] s2;
    always_comb begin
        s1      = div_step(pr, lo[W-1], dvs);
        s2      = div_step(s1[W:1], lo[W-2], dvs);
        pr_step = s2[W:1];
        lo_step = {lo[W-3:0], s1[0], s2[0]};
    end
`else
    always_comb begin
        s1      = div_step(pr, lo[W-1], dvs);
        pr_step = s1[W:1];
        lo_step = {lo[W-2:0], s1[0]};
    end
`endif

    // Sign correction and signed range check of the finished magnitudes
    always_comb begin
        q_fix = qneg ? (~lo + W'(1)) : lo;
        r_fix = rneg ? (~pr + W'(1)) : pr;
        sovf  = qneg ? (lo > HALF) : lo[W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (cen) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (dz_c || ovf_c) ? FIN : RUN;
            RUN:  if (cnt == LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIX commits a computed result, FIN commits an early-detected overflow
    always_comb begin
        commit   = 1'b0;
        q_nxt    = quot;
        r_nxt    = rem;
        v_nxt    = v;
        dz_nxt   = dz;
        busy_nxt = (state_nxt != IDLE);
        case (state)
            FIX: begin
                commit = 1'b1;
                dz_nxt = 1'b0;
                if (sovf) begin
                    q_nxt = '1;
                    r_nxt = lo_raw;
                    v_nxt = 1'b1;
                end else begin
                    q_nxt = q_fix;
                    r_nxt = r_fix;
                    v_nxt = 1'b0;
                end
            end
            FIN: begin
                commit = 1'b1;
                q_nxt  = '1;
                r_nxt  = lo_raw;
                v_nxt  = 1'b1;
                dz_nxt = dz_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            pr     <= '0;
            lo     <= '0;
            dvs    <= '0;
            lo_raw <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            dz_r   <= 1'b0;
        end else if (cen) begin
            case (state)
                IDLE: if (start) begin
                    pr     <= dvd_mag_c[DW-1:W];
                    lo     <= dvd_mag_c[W-1:0];
                    dvs    <= dvs_mag_c;
                    lo_raw <= dvd_c[W-1:0];
                    qneg   <= dvd_neg_c ^ dvs_neg_c;
                    rneg   <= dvd_neg_c;
                    dz_r   <= dz_c;
                    cnt    <= '0;
                end
                RUN: begin
                    pr  <= pr_step;
                    lo  <= lo_step;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Results only move on a commit so they stay stable while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot <= '0;
            rem  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            v    <= 1'b0;
            dz   <= 1'b0;
        end else if (cen) begin
            busy <= busy_nxt;
            done <= commit;
            if (commit) begin
                quot <= q_nxt;
                rem  <= r_nxt;
                v    <= v_nxt;
                dz   <= dz_nxt;
            end
        end
    end

endmodule

// File: tb/tb_jtkcpu_seqdiv.sv
// Self-checking bench for jtkcpu_seqdiv (W=8): scoreboard of expected results, popped on each done.
module tb_jtkcpu_seqdiv;

    localparam int W = 8;
`ifdef JTKCPU_SEQDIV_RADIX4_EN
    localparam int NB = W / 2 + 1;
`else
    localparam int NB = W + 1;
`endif

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       v;
        logic       dz;
        int         blen;
    } exp_t;

    logic        rst, clk, cen, start, sign, len;
    logic [15:0] op0;
    logic [7:0]  op1;
    logic [7:0]  quot, rem;
    logic        busy, done, v, dz;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cen_mode = 0;
    exp_t sb[$];

    jtkcpu_seqdiv #(.W(W)) dut (
        .rst(rst), .clk(clk), .cen(cen), .start(start), .sign(sign), .len(len),
        .op0(op0), .op1(op1), .quot(quot), .rem(rem), .busy(busy), .done(done),
        .v(v), .dz(dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cen changes on the falling edge so it is stable around each rising edge
    initial begin : cen_gen
        int ph;
        ph  = 0;
        cen = 1'b1;
        forever begin
            @(negedge clk);
            ph  = (ph + 1) % 3;
            cen = (cen_mode == 0) ? 1'b1 : (ph == 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic s, input logic l, input logic [15:0] a0,
                                   input logic [7:0] b0);
        exp_t        e;
        logic [15:0] dvd;
        longint      a, b, q, r, aa, bb;
        bit          ovf, early;
        dvd = l ? a0 : (s ? {{8{a0[7]}}, a0[7:0]} : {8'h00, a0[7:0]});
        if (s) begin
            a = longint'($signed(dvd));
            b = longint'($signed(b0));
        end else begin
            a = longint'(dvd);
            b = longint'(b0);
        end
        aa = (a < 0) ? -a : a;
        bb = (b < 0) ? -b : b;
        e.dz = (b == 0);
        if (b == 0) begin
            e.v = 1'b1; e.q = 8'hFF; e.r = dvd[7:0]; e.blen = 1;
        end else begin
            q     = a / b;
            r     = a % b;
            early = (aa / 256 >= bb);
            ovf   = s ? (q > 127 || q < -128) : (q > 255);
            e.v   = ovf;
            e.q   = ovf ? 8'hFF : 8'(q);
            e.r   = ovf ? dvd[7:0] : 8'(r);
            e.blen = early ? 1 : NB;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r, input logic vv,
                                input logic z, input int bl);
        exp_t e;
        e.q = q; e.r = r; e.v = vv; e.dz = z; e.blen = bl;
        return e;
    endfunction

    // Drives one request and waits for its done; returns what the DUT showed, no checking of results
    task automatic run_op(input logic s, input logic l, input logic [15:0] a, input logic [7:0] b,
                          input bit junk, output logic [7:0] q, output logic [7:0] r,
                          output logic ov, output logic z, output int blen, output int acc,
                          output bit ok);
        logic [7:0] q0, r0;
        int         guard;
        ok = 1; blen = 0; acc = 0;
        sign = s; len = l; op0 = a; op1 = b; start = 1'b1;
        do begin
            @(posedge clk); #1;
            acc++;
        end while (!cen && acc < 20);
        start = 1'b0;
        if (busy !== 1'b1) ok = 0;
        q0 = quot; r0 = rem;
        guard = 0;
        while (done !== 1'b1 && guard < 300) begin
            if (junk) begin
                start = guard[0];
                op0   = 16'($urandom);
                op1   = 8'($urandom);
                sign  = 1'($urandom);
            end
            @(posedge clk); #1;
            guard++;
            if (cen) blen++;
            if (done !== 1'b1 && (quot !== q0 || rem !== r0 || busy !== 1'b1)) ok = 0;
        end
        start = 1'b0;
        if (done !== 1'b1 || busy !== 1'b0) ok = 0;
        q = quot; r = rem; ov = v; z = dz;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sign = 1'b0; len = 1'b0; op0 = '0; op1 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({quot, rem, busy, done, v, dz} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_values: got q=%h r=%h busy=%b done=%b v=%b dz=%b, want all zero",
                     quot, rem, busy, done, v, dz);
        end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_unsigned();
        logic [7:0] q, r; logic ov, z; int bl, acc; bit ok; exp_t e;
        sb.push_back(mk(8'h0E, 8'h02, 1'b0, 1'b0, NB));
        run_op(1'b0, 1'b1, 16'h0064, 8'h07, 1'b0, q, r, ov, z, bl, acc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || {q, r, ov, z} !== {e.q, e.r, e.v, e.dz} || bl != e.blen) begin
            n_fail++;
            $display("FAIL unsigned_100_by_7: got q=%h r=%h v=%b dz=%b busy=%0d ok=%0b, want q=%h r=%h v=%b dz=%b busy=%0d",
                     q, r, ov, z, bl, ok, e.q, e.r, e.v, e.dz, e.blen);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single_pulse: got done=%b busy=%b one cycle later, want 0 0", done, busy);
        end
    endtask

    task automatic test_signed();
        logic [7:0] q, r; logic ov, z; int bl, acc; bit ok; exp_t e;
        logic        s_t[3] = '{1'b1, 1'b1, 1'b1};
        logic        l_t[3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] a_t[3] = '{16'hFF9C, 16'hFF80, 16'hA59C};
        logic [7:0]  b_t[3] = '{8'h07, 8'h01, 8'h07};
        sb.push_back(mk(8'hF2, 8'hFE, 1'b0, 1'b0, NB));
        sb.push_back(mk(8'h80, 8'h00, 1'b0, 1'b0, NB));
        sb.push_back(mk(8'hF2, 8'hFE, 1'b0, 1'b0, NB));
        for (int i = 0; i < 3; i++) begin
            run_op(s_t[i], l_t[i], a_t[i], b_t[i], 1'b0, q, r, ov, z, bl, acc, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || {q, r, ov, z} !== {e.q, e.r, e.v, e.dz} || bl != e.blen) begin
                n_fail++;
                $display("FAIL signed_case%0d: got q=%h r=%h v=%b dz=%b busy=%0d ok=%0b, want q=%h r=%h v=%b dz=%b busy=%0d",
                         i, q, r, ov, z, bl, ok, e.q, e.r, e.v, e.dz, e.blen);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic ov, z; int bl, acc; bit ok; exp_t e;
        sb.push_back(mk(8'hFF, 8'h34, 1'b1, 1'b1, 1));
        run_op(1'b0, 1'b1, 16'h1234, 8'h00, 1'b0, q, r, ov, z, bl, acc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || {q, r, ov, z} !== {e.q, e.r, e.v, e.dz} || bl != e.blen) begin
            n_fail++;
            $display("FAIL div_by_zero: got q=%h r=%h v=%b dz=%b busy=%0d ok=%0b, want q=%h r=%h v=%b dz=%b busy=%0d",
                     q, r, ov, z, bl, ok, e.q, e.r, e.v, e.dz, e.blen);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q, r; logic ov, z; int bl, acc; bit ok; exp_t e;
        logic        s_t[2] = '{1'b0, 1'b1};
        logic [15:0] a_t[2] = '{16'h0800, 16'h0080};
        logic [7:0]  b_t[2] = '{8'h08, 8'h01};
        sb.push_back(mk(8'hFF, 8'h00, 1'b1, 1'b0, 1));
        sb.push_back(mk(8'hFF, 8'h80, 1'b1, 1'b0, NB));
        for (int i = 0; i < 2; i++) begin
            run_op(s_t[i], 1'b1, a_t[i], b_t[i], 1'b0, q, r, ov, z, bl, acc, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || {q, r, ov, z} !== {e.q, e.r, e.v, e.dz} || bl != e.blen) begin
                n_fail++;
                $display("FAIL overflow_case%0d: got q=%h r=%h v=%b dz=%b busy=%0d ok=%0b, want q=%h r=%h v=%b dz=%b busy=%0d",
                         i, q, r, ov, z, bl, ok, e.q, e.r, e.v, e.dz, e.blen);
            end
        end
    endtask

    task automatic test_cen_gating();
        logic [7:0] q, r; logic ov, z; int bl, acc; bit ok, hold_ok; exp_t e;
        cen_mode = 1;
        @(negedge clk);
        @(posedge clk); #1;
        sb.push_back(mk(8'h0E, 8'h02, 1'b0, 1'b0, NB));
        run_op(1'b0, 1'b1, 16'h0064, 8'h07, 1'b1, q, r, ov, z, bl, acc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || {q, r, ov, z} !== {e.q, e.r, e.v, e.dz} || bl != e.blen) begin
            n_fail++;
            $display("FAIL cen_gated_run: got q=%h r=%h v=%b dz=%b busy=%0d ok=%0b, want q=%h r=%h v=%b dz=%b busy=%0d",
                     q, r, ov, z, bl, ok, e.q, e.r, e.v, e.dz, e.blen);
        end
        hold_ok = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (!cen && done !== 1'b1) break;
            if (cen) begin
                hold_ok = (done === 1'b0);
                break;
            end
        end
        n_checks++;
        if (!hold_ok) begin
            n_fail++;
            $display("FAIL done_hold_on_cen_low: got done=%b cen=%b, want held 1 until next cen edge then 0", done, cen);
        end
        hold_ok = 1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) hold_ok = 0;
        end
        n_checks++;
        if (!hold_ok) begin
            n_fail++;
            $display("FAIL busy_start_not_queued: got done=%b busy=%b after run, want 0 0", done, busy);
        end
        cen_mode = 0;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, r; logic ov, z; int bl, acc; bit ok; exp_t e;
        logic        s_t[3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] a_t[3] = '{16'h0064, 16'hFF9C, 16'h1234};
        logic [7:0]  b_t[3] = '{8'h07, 8'h07, 8'h00};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(model(s_t[i], 1'b1, a_t[i], b_t[i]));
            run_op(s_t[i], 1'b1, a_t[i], b_t[i], 1'b0, q, r, ov, z, bl, acc, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || {q, r, ov, z} !== {e.q, e.r, e.v, e.dz} || bl != e.blen
                || (i > 0 && acc != 1)) begin
                n_fail++;
                $display("FAIL back_to_back%0d: got q=%h r=%h v=%b dz=%b busy=%0d accept_wait=%0d, want q=%h r=%h v=%b dz=%b busy=%0d accept_wait=1",
                         i, q, r, ov, z, bl, acc, e.q, e.r, e.v, e.dz, e.blen);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] q, r; logic ov, z; int bl, acc; bit ok, quiet; exp_t e;
        sign = 1'b0; len = 1'b1; op0 = 16'h0064; op1 = 8'h07; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({quot, rem, busy, done, v, dz} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got q=%h r=%h busy=%b done=%b v=%b dz=%b, want all zero",
                     quot, rem, busy, done, v, dz);
        end
        @(negedge clk) rst = 1'b0;
        quiet = 1;
        repeat (15) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL no_done_after_abort: got done=%b busy=%b, want 0 0", done, busy);
        end
        sb.push_back(mk(8'hF2, 8'hFE, 1'b0, 1'b0, NB));
        run_op(1'b1, 1'b1, 16'hFF9C, 8'h07, 1'b0, q, r, ov, z, bl, acc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || {q, r, ov, z} !== {e.q, e.r, e.v, e.dz} || bl != e.blen) begin
            n_fail++;
            $display("FAIL after_reset_run: got q=%h r=%h v=%b dz=%b busy=%0d ok=%0b, want q=%h r=%h v=%b dz=%b busy=%0d",
                     q, r, ov, z, bl, ok, e.q, e.r, e.v, e.dz, e.blen);
        end
    endtask

    task automatic test_random();
        logic [7:0] q, r, b; logic ov, z, s, l; int bl, acc; bit ok; exp_t e;
        logic [15:0] a;
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            l = 1'($urandom);
            a = 16'($urandom);
            b = 8'($urandom);
            case (i % 4)
                1: a = {{8{a[7]}}, a[7:0]};
                2: a = {8'($urandom_range(0, 3)), a[7:0]};
                3: if (i % 8 == 3) b = 8'h00;
                default: ;
            endcase
            sb.push_back(model(s, l, a, b));
            run_op(s, l, a, b, 1'b0, q, r, ov, z, bl, acc, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || {q, r, ov, z} !== {e.q, e.r, e.v, e.dz} || bl != e.blen) begin
                n_fail++;
                $display("FAIL random%0d s=%b l=%b op0=%h op1=%h: got q=%h r=%h v=%b dz=%b busy=%0d ok=%0b, want q=%h r=%h v=%b dz=%b busy=%0d",
                         i, s, l, a, b, q, r, ov, z, bl, ok, e.q, e.r, e.v, e.dz, e.blen);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_cen_gating();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
